// File: rtl/logic_slice_unit_if.sv
// Handshake and data bus of logic_slice_unit: request side (START/OP/A/B)
// and result side (Y/ZERO/BUSY/DONE).
interface logic_slice_unit_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [2:0]       OP;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Y;
    logic             ZERO;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, OP, A, B,
        input  Y, ZERO, BUSY, DONE
    );

    modport slave (
        input  START, OP, A, B,
        output Y, ZERO, BUSY, DONE
    );
endinterface

// File: rtl/logic_slice_unit.sv
// Multi-cycle bitwise logic unit: latches operands on START, then computes
// SLICE result bits per cycle (LSB slice first) and pulses DONE.
module logic_slice_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                CLK,
    input  logic                RST,
    logic_slice_unit_if.slave   bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
        $error("logic_slice_unit: SLICE must divide WIDTH and satisfy 1 <= SLICE <= WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOR  = 3'b010,
        OP_NOTA = 3'b011,
        OP_BUFA = 3'b100,
        OP_XOR  = 3'b101,
        OP_NAND = 3'b110,
        OP_XNOR = 3'b111
    } op_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    op_t              op_q;
    logic [WIDTH-1:0] y_q;

    logic             last_slice;
    logic [31:0]      base;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_res;
    logic             busy;
    logic             done;

    assign last_slice = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; START is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.START) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_IDLE:  begin busy = 1'b0; done = 1'b0; end
            S_RUN:   begin busy = 1'b1; done = 1'b0; end
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: begin busy = 1'b0; done = 1'b0; end
        endcase
    end

    // Current slice operation, selected by the slice counter
    always_comb begin
        base      = 32'(cnt_q) * 32'(SLICE);
        slice_a   = a_q[base +: SLICE];
        slice_b   = b_q[base +: SLICE];
        slice_res = '0;
        unique case (op_q)
            OP_AND:  slice_res = slice_a & slice_b;
            OP_OR:   slice_res = slice_a | slice_b;
            OP_NOR:  slice_res = ~(slice_a | slice_b);
            OP_NOTA: slice_res = ~slice_a;
            OP_BUFA: slice_res = slice_a;
            OP_XOR:  slice_res = slice_a ^ slice_b;
            OP_NAND: slice_res = ~(slice_a & slice_b);
            OP_XNOR: slice_res = ~(slice_a ^ slice_b);
            default: slice_res = '0;
        endcase
    end

    // Operand latch, slice counter and result register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_AND;
            y_q   <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.START) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        op_q  <= op_t'(bus.OP);
                        y_q   <= '0;
                        cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    y_q[base +: SLICE] <= slice_res;
                    cnt_q              <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.Y    = y_q;
    assign bus.ZERO = (y_q == '0);
    assign bus.BUSY = busy;
    assign bus.DONE = done;
endmodule

// File: tb/tb_logic_slice_unit.sv
// Scoreboard bench for logic_slice_unit: randomized and directed traffic on a
// 32/8 instance, plus directed runs on 64/64 and 32/1 instances.
module tb_logic_slice_unit;
    localparam int N = 4;

    logic clk;
    logic rst_n;

    logic_slice_unit_if #(.WIDTH(32)) bus32 ();
    logic_slice_unit_if #(.WIDTH(64)) bus64 ();
    logic_slice_unit_if #(.WIDTH(32)) bus1 ();

    logic_slice_unit #(.WIDTH(32), .SLICE(8)) u_dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus32)
    );

    logic_slice_unit #(.WIDTH(64), .SLICE(64)) u_dut64 (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus64)
    );

    logic_slice_unit #(.WIDTH(32), .SLICE(1)) u_dut1 (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus1)
    );

    typedef struct {
        logic [31:0] y;
        int          done_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_count = 0;
    int   acc_edge = -100;
    int   free_edge = 0;
    bit   in_reset = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    function automatic logic [63:0] model_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a | b);
            3'd3:    return ~a;
            3'd4:    return a;
            3'd5:    return a ^ b;
            3'd6:    return ~(a & b);
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of request inputs; the model decides whether this edge accepts.
    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit acc);
        exp_t        e;
        logic [63:0] r;
        @(negedge clk);
        bus32.START = s;
        bus32.OP    = op;
        bus32.A     = a;
        bus32.B     = b;
        acc = 1'b0;
        if (s && (edge_count + 1 >= free_edge)) begin
            r           = model_op(op, {32'b0, a}, {32'b0, b});
            e.y         = r[31:0];
            e.done_edge = edge_count + 1 + N;
            sb.push_back(e);
            acc_edge  = edge_count + 1;
            free_edge = edge_count + 1 + N + 2;
            acc = 1'b1;
        end
    endtask

    // Monitor: compares BUSY every cycle, DONE timing and the result at DONE.
    always @(negedge clk) begin
        int   ec;
        bit   exp_busy;
        bit   exp_done;
        exp_t e;
        if (!in_reset) begin
            ec       = edge_count;
            exp_busy = (ec >= acc_edge) && (ec <= acc_edge + N);
            exp_done = (sb.size() > 0) && (sb[0].done_edge == ec);
            chk("busy", {63'b0, bus32.BUSY}, {63'b0, exp_busy});
            chk("done", {63'b0, bus32.DONE}, {63'b0, exp_done});
            if (exp_done) begin
                e = sb.pop_front();
                chk("y", {32'b0, bus32.Y}, {32'b0, e.y});
                chk("zero", {63'b0, bus32.ZERO}, {63'b0, (e.y == 32'd0)});
            end
        end
    end

    initial begin
        bit          acc;
        int          e0;
        int          k;
        logic [63:0] r64;
        logic [63:0] r1;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        bus32.START = 1'b0; bus32.OP = '0; bus32.A = '0; bus32.B = '0;
        bus64.START = 1'b0; bus64.OP = '0; bus64.A = '0; bus64.B = '0;
        bus1.START  = 1'b0; bus1.OP  = '0; bus1.A  = '0; bus1.B  = '0;
        #3;
        chk("rst_y", {32'b0, bus32.Y}, 64'd0);
        chk("rst_zero", {63'b0, bus32.ZERO}, 64'd1);
        chk("rst_busy", {63'b0, bus32.BUSY}, 64'd0);
        chk("rst_done", {63'b0, bus32.DONE}, 64'd0);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_reset = 1'b0;

        // Directed: AND, NOR to zero, XOR with START held through RUN/DONE
        drive(1'b1, 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, acc);
        repeat (6) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);
        drive(1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000000, acc);
        repeat (6) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);
        drive(1'b1, 3'b101, 32'h12345678, 32'hFFFFFFFF, acc);
        repeat (10) drive(1'b1, 3'b000, 32'h0, 32'h0, acc);
        repeat (6) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h0;
                1:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, rb, acc);
        end
        repeat (8) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);

        // Asynchronous reset after two slices of an XNOR run
        drive(1'b1, 3'b111, 32'hA5A5A5A5, 32'h3C3C3C3C, acc);
        chk("abort_accept", {63'b0, acc}, 64'd1);
        repeat (3) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);
        #2;
        in_reset = 1'b1;
        rst_n    = 1'b0;
        sb.delete();
        acc_edge  = -100;
        free_edge = 0;
        #1;
        chk("abort_y", {32'b0, bus32.Y}, 64'd0);
        chk("abort_busy", {63'b0, bus32.BUSY}, 64'd0);
        chk("abort_done", {63'b0, bus32.DONE}, 64'd0);
        chk("abort_zero", {63'b0, bus32.ZERO}, 64'd1);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_reset = 1'b0;
        repeat (8) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);
        drive(1'b1, 3'b001, 32'h00F000F0, 32'h0F000F00, acc);
        chk("post_reset_accept", {63'b0, acc}, 64'd1);
        repeat (8) drive(1'b0, 3'b000, 32'h0, 32'h0, acc);
        chk("drain", 64'(sb.size()), 64'd0);

        // WIDTH=64, SLICE=64: one RUN cycle
        @(negedge clk);
        bus64.START = 1'b1; bus64.OP = 3'b011; bus64.A = 64'h0;
        bus64.B = {$urandom, $urandom};
        r64 = model_op(3'b011, 64'h0, bus64.B);
        @(negedge clk);
        bus64.START = 1'b0;
        chk("w64_busy_run", {63'b0, bus64.BUSY}, 64'd1);
        chk("w64_done_run", {63'b0, bus64.DONE}, 64'd0);
        @(negedge clk);
        chk("w64_done", {63'b0, bus64.DONE}, 64'd1);
        chk("w64_y", bus64.Y, r64);
        chk("w64_zero", {63'b0, bus64.ZERO}, 64'd0);
        @(negedge clk);
        chk("w64_done_after", {63'b0, bus64.DONE}, 64'd0);
        chk("w64_busy_after", {63'b0, bus64.BUSY}, 64'd0);
        chk("w64_y_hold", bus64.Y, r64);

        // WIDTH=32, SLICE=1: LSB-first order and 32-edge latency
        @(negedge clk);
        bus1.START = 1'b1; bus1.OP = 3'b100; bus1.A = 32'h80000001;
        bus1.B = $urandom;
        r1 = model_op(3'b100, 64'h80000001, {32'b0, bus1.B});
        e0 = edge_count + 1;
        @(negedge clk);
        bus1.START = 1'b0;
        bus1.A = 32'h0;
        @(negedge clk);
        chk("s1_after1", {32'b0, bus1.Y}, r1 & 64'h1);
        repeat (15) @(negedge clk);
        chk("s1_after16", {32'b0, bus1.Y}, r1 & 64'hFFFF);
        k = 0;
        while (!bus1.DONE && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("s1_done_seen", {63'b0, bus1.DONE}, 64'd1);
        chk("s1_latency", 64'(edge_count - e0), 64'd32);
        chk("s1_y", {32'b0, bus1.Y}, r1);
        chk("s1_zero", {63'b0, bus1.ZERO}, 64'd0);
        @(negedge clk);
        chk("s1_done_pulse", {63'b0, bus1.DONE}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_slice_unit.md
LOGIC_SLICE_UNIT -- requirements
Module: logic_slice_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits processed per cycle; WIDTH % SLICE == 0 and 1 <= SLICE <= WIDTH are required. N = WIDTH/SLICE.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port START  input  1  request to begin an operation.
REQ-006 SHALL have port OP  input  3  operation select: 000 AND, 001 OR, 010 NOR, 011 NOT A, 100 BUF A, 101 XOR, 110 NAND, 111 XNOR.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand; ignored for NOT/BUF.
REQ-009 SHALL have port Y  output  WIDTH  registered result.
REQ-010 SHALL have port ZERO  output  1  high when Y == 0.
REQ-011 SHALL have port BUSY  output  1  high whenever state != IDLE.
REQ-012 SHALL have port DONE  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; BUSY and DONE are Moore outputs decoded from state.
REQ-014 SHALL, in IDLE with START=1 at a rising edge, latch A, B and OP into internal registers, clear Y to 0, clear slice counter to 0, go to RUN.
REQ-015 SHALL, in IDLE with START=0, hold state, Y and ZERO unchanged.
REQ-016 SHALL, on each RUN edge, write Y[cnt*SLICE +: SLICE] = f(latched A slice, latched B slice, latched OP), increment cnt; other Y bits unchanged.
REQ-017 SHALL go RUN -> DONE on the edge writing slice N-1 (cnt == N-1); SLICE == WIDTH gives exactly one RUN cycle.
REQ-018 SHALL go DONE -> IDLE unconditionally on the next edge; DONE high for exactly that one cycle.
REQ-019 SHALL give latency: DONE high in the cycle following the Nth edge after the accepting edge; next accept is possible no earlier than edge N+2.
REQ-020 SHALL ignore START while BUSY=1 (RUN or DONE), including in the DONE cycle.
REQ-021 SHALL ignore changes on A, B, OP after acceptance; result depends only on latched values.
REQ-022 SHALL hold Y from DONE until the next accepted START (Y valid while DONE=1 and after, in IDLE).
REQ-023 SHALL compute ZERO combinationally from registered Y (ZERO=1 during RUN after clear is permitted; only valid when DONE=1 or in IDLE).
REQ-024 SHALL apply every operation bitwise; no carries or cross-bit dependence; counter width ceil(log2(N)) with minimum 1 bit.

Reset
REQ-025 SHALL, while RST=0, immediately force state IDLE, cnt=0, Y=0, latched operands/OP=0, BUSY=0, DONE=0, ZERO=1, regardless of CLK.
REQ-026 SHALL abort any in-flight operation on reset with no DONE pulse; first accept possible on first rising edge with RST=1 and START=1.

Verification (WIDTH=32, SLICE=8, N=4 unless stated)
REQ-027 SHALL cover: OP=000, A=0xFFFF0000, B=0x0F0F0F0F, START one cycle -> BUSY high 5 cycles, DONE pulse 4 edges after accept, Y=0x0F0F0000, ZERO=0.
REQ-028 SHALL cover: OP=010, A=0xFFFFFFFF, B=0x00000000 -> Y=0x00000000, ZERO=1 with DONE.
REQ-029 SHALL cover: accept OP=101 A=0x12345678 B=0xFFFFFFFF, then drive START=1, OP=000, A=B=0 during RUN/DONE -> ignored, Y=0xEDCBA987; with START held high, second op accepted at edge N+2 exactly.
REQ-030 SHALL cover: RST pulled low asynchronously mid-RUN (after 2 slices) -> Y=0, BUSY=0, DONE=0 immediately, no DONE pulse afterward.
REQ-031 SHALL cover: WIDTH=64, SLICE=64, OP=011, A=0 -> one RUN cycle, DONE next cycle, Y=0xFFFFFFFFFFFFFFFF, ZERO=0.
REQ-032 SHALL cover: WIDTH=32, SLICE=1, OP=100, A=0x80000001 -> DONE 32 edges after accept, Y=0x80000001; slice-order check by sampling Y mid-run (after 1 edge Y=0x00000001).
